// File: rtl/bit_timer_pkg.sv
// -----------------------------------------------------------------------------
// bit_timer_pkg
// Shared types and default timing constants for the USB receive bit timer.
// The default constants are also used by the byte-level receive controller.
// -----------------------------------------------------------------------------
package bit_timer_pkg;

  // Bit timer FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // held / not started, no strobes
    FIRST = 2'd1,  // counting down to the first sample point
    RUN   = 2'd2   // periodic sampling once per bit period
  } bt_state_t;

  // Default timing for full-speed receive at the system clock rate.
  localparam int BT_CLKS_PER_BIT  = 30;
  localparam int BT_FIRST_OFFSET  = 15;
  localparam int BT_BITS_PER_BYTE = 8;
  localparam int BT_RESYNC        = 1;

endpackage

// File: rtl/bit_timer_byte_cnt.sv
// -----------------------------------------------------------------------------
// bit_timer_byte_cnt
// Counts issued sample strobes into bytes. A strobe with hold_count set is a
// stuff bit: it is not counted and cannot complete a byte.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-low reset
//   clear         synchronous clear (timer restart), wins over counting
//   strobe_issue  high on the edge that registers a shift_enable strobe
//   hold_count    stuff-bit marker, sampled with strobe_issue
//   bit_idx       bits counted in the current byte
//   byte_done     one-cycle pulse aligned with the strobe completing a byte
// -----------------------------------------------------------------------------
module bit_timer_byte_cnt
  import bit_timer_pkg::*;
#(
  parameter  int BITS_PER_BYTE = BT_BITS_PER_BYTE,
  localparam int BIT_W         = $clog2(BITS_PER_BYTE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             strobe_issue,
  input  logic             hold_count,
  output logic [BIT_W-1:0] bit_idx,
  output logic             byte_done
);

  localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(BITS_PER_BYTE - 1);

  // Registered on the same edge as shift_enable, so bit_idx and byte_done
  // change in the same cycle the strobe is visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_idx   <= '0;
      byte_done <= 1'b0;
    end else if (clear) begin
      bit_idx   <= '0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      if (strobe_issue && !hold_count) begin
        if (bit_idx == LAST_IDX) begin
          bit_idx   <= '0;
          byte_done <= 1'b1;
        end else begin
          bit_idx <= bit_idx + BIT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/bit_timer.sv
// -----------------------------------------------------------------------------
// bit_timer
// Receive bit-timing generator. After reset_timer is released it strobes
// shift_enable FIRST_OFFSET cycles later, then every CLKS_PER_BIT cycles.
// With RESYNC=1 an edge_det pulse moves the next strobe HALF cycles out,
// re-centring the sample point on the data eye.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-low reset
//   reset_timer   synchronous hold/restart, highest priority
//   edge_det      one-cycle pulse on a data-line transition
//   hold_count    stuff-bit marker, sampled at the edge a strobe is issued
//   shift_enable  registered one-cycle sample strobe
//   byte_done     registered one-cycle pulse with the byte-completing strobe
//   bit_idx       bits counted in the current byte
//   state_dbg     current FSM state (observation only)
//
// Handshake: none. All outputs are single-cycle strobes or levels; the
// consumer samples them every cycle and there is no back-pressure.
// -----------------------------------------------------------------------------
module bit_timer
  import bit_timer_pkg::*;
#(
  parameter  int CLKS_PER_BIT  = BT_CLKS_PER_BIT,
  parameter  int FIRST_OFFSET  = BT_FIRST_OFFSET,
  parameter  int BITS_PER_BYTE = BT_BITS_PER_BYTE,
  parameter  int RESYNC        = BT_RESYNC,
  localparam int BIT_W         = $clog2(BITS_PER_BYTE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reset_timer,
  input  logic             edge_det,
  input  logic             hold_count,
  output logic             shift_enable,
  output logic             byte_done,
  output logic [BIT_W-1:0] bit_idx,
  output bt_state_t        state_dbg
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int HALF  = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] FIRST_LOAD  = CNT_W'(FIRST_OFFSET - 1);
  localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] RESYNC_LOAD = CNT_W'(HALF - 1);

  // Parameter range checks at elaboration.
  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 255) begin : g_bad_clks
    $error("bit_timer: CLKS_PER_BIT must be in 4..255");
  end
  if (FIRST_OFFSET < 1 || FIRST_OFFSET > CLKS_PER_BIT) begin : g_bad_first
    $error("bit_timer: FIRST_OFFSET must be in 1..CLKS_PER_BIT");
  end
  if (BITS_PER_BYTE < 2) begin : g_bad_bits
    $error("bit_timer: BITS_PER_BYTE must be at least 2");
  end
  if (RESYNC != 0 && RESYNC != 1) begin : g_bad_resync
    $error("bit_timer: RESYNC must be 0 or 1");
  end

  bt_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             strobe_issue;

  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_enable <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_enable <= strobe_issue;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    strobe_issue = 1'b0;
    // reset_timer drops any strobe that would have been issued this edge.
    if (reset_timer) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = FIRST;
          cnt_d   = FIRST_LOAD;
        end
        FIRST, RUN: begin
          if (cnt_q == '0) begin
            strobe_issue = 1'b1;
            cnt_d        = PERIOD_LOAD;
            state_d      = RUN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
          // A line transition re-centres the phase; it overrides the period
          // reload even when a strobe goes out on the same edge, and does not
          // advance FIRST to RUN.
          if (RESYNC != 0 && edge_det) begin
            cnt_d   = RESYNC_LOAD;
            state_d = state_q;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  bit_timer_byte_cnt #(
    .BITS_PER_BYTE(BITS_PER_BYTE)
  ) u_byte_cnt (
    .clk          (clk),
    .rst          (rst),
    .clear        (reset_timer),
    .strobe_issue (strobe_issue),
    .hold_count   (hold_count),
    .bit_idx      (bit_idx),
    .byte_done    (byte_done)
  );

endmodule

// File: tb/tb_bit_timer.sv
module tb_bit_timer;
  import bit_timer_pkg::*;

  localparam int W = 20;  // {edge[15:0], byte_done, bit_idx[2:0]}

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc  = 0;
  int base = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------------------------------------------------------- DUTs
  logic            reset_timer, edge_det, hold_count;
  logic            se0, bd0;
  logic [2:0]      idx0;
  bt_state_t       st0;

  logic            reset_timer1, edge_det1;
  logic            se1, bd1;
  logic [2:0]      idx1;
  bt_state_t       st1;

  bit_timer dut (
    .clk          (clk),
    .rst          (rst),
    .reset_timer  (reset_timer),
    .edge_det     (edge_det),
    .hold_count   (hold_count),
    .shift_enable (se0),
    .byte_done    (bd0),
    .bit_idx      (idx0),
    .state_dbg    (st0)
  );

  bit_timer #(.RESYNC(0)) dut_nrs (
    .clk          (clk),
    .rst          (rst),
    .reset_timer  (reset_timer1),
    .edge_det     (edge_det1),
    .hold_count   (1'b0),
    .shift_enable (se1),
    .byte_done    (bd1),
    .bit_idx      (idx1),
    .state_dbg    (st1)
  );

  // edge_det toggles randomly on the no-resync build; it must have no effect.
  initial edge_det1 = 1'b0;
  always @(posedge clk) begin
    #1 edge_det1 = 1'($urandom_range(0, 1));
  end

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------------------------------------------------------- scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_q1[$];

  task automatic push(input int e, input bit d, input int idx, input bit both);
    exp_q.push_back({16'(e), d, 3'(idx)});
    if (both) exp_q1.push_back({16'(e), d, 3'(idx)});
  endtask

  always @(negedge clk) begin
    logic [W-1:0] obs, e;
    if (rst && se0) begin
      obs = {16'(cyc - base), bd0, idx0};
      if (exp_q.size() == 0) check_eq("strobe_unexp", 32'(obs), 32'hFFFFF);
      else begin
        e = exp_q.pop_front();
        check_eq("strobe", 32'(obs), 32'(e));
      end
    end
    if (rst && bd0 && !se0) check_eq("done_alone", 32'(bd0), 32'd0);
    if (rst && se1) begin
      obs = {16'(cyc - base), bd1, idx1};
      if (exp_q1.size() == 0) check_eq("strobe_nrs_unexp", 32'(obs), 32'hFFFFF);
      else begin
        e = exp_q1.pop_front();
        check_eq("strobe_nrs", 32'(obs), 32'(e));
      end
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called between edges with reset_timer high; the next edge is edge 0.
  task automatic run(input int end_e, input int resync_e, input int hold_e, input int rtp_e);
    base        = cyc + 1;
    reset_timer = 1'b0;
    for (int e = 0; e <= end_e; e++) begin
      edge_det    = (e == resync_e);
      hold_count  = (e == hold_e);
      reset_timer = (e == rtp_e);
      tick();
      if (e == rtp_e) begin
        check_eq("rtp_outputs", 32'({se0, bd0, idx0}), 32'd0);
        check_eq("rtp_state", 32'(st0), 32'(IDLE));
      end
    end
    edge_det   = 1'b0;
    hold_count = 1'b0;
  endtask

  task automatic stop(input string tag);
    reset_timer  = 1'b1;
    reset_timer1 = 1'b1;
    tick();
    check_eq({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    check_eq({tag, "_q1_empty"}, 32'(exp_q1.size()), 32'd0);
    repeat ($urandom_range(2, 6)) tick();
    check_eq({tag, "_held_out"}, 32'({se0, bd0, idx0}), 32'd0);
    check_eq({tag, "_held_state"}, 32'(st0), 32'(IDLE));
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst          = 1'b0;
    reset_timer  = 1'b1;
    reset_timer1 = 1'b1;
    edge_det     = 1'b0;
    hold_count   = 1'b0;
    repeat (3) tick();
    check_eq("reset_out", 32'({se0, bd0, idx0}), 32'd0);
    check_eq("reset_state", 32'(st0), 32'(IDLE));
    check_eq("reset_out_nrs", 32'({se1, bd1, idx1}), 32'd0);
    rst = 1'b1;
    repeat (3) tick();
    check_eq("held_after_rst", 32'({se0, bd0, idx0}), 32'd0);

    // Baseline: strobes at 15 + 30k, byte_done on the 8th; the no-resync
    // build with random edge_det must match exactly.
    for (int k = 0; k < 9; k++) push(15 + 30 * k, k == 7, (k + 1) % 8, 1'b1);
    reset_timer1 = 1'b0;
    run(262, -1, -1, -1);
    stop("base");

    // Resync at edge 50 in RUN: strobes 65, 95; none at 75.
    push(15, 0, 1, 0); push(45, 0, 2, 0); push(65, 0, 3, 0); push(95, 0, 4, 0);
    run(98, 50, -1, -1);
    stop("resync50");

    // Resync on the strobe edge 45: strobe kept, next at 60.
    push(15, 0, 1, 0); push(45, 0, 2, 0); push(60, 0, 3, 0); push(90, 0, 4, 0);
    run(95, 45, -1, -1);
    stop("resync45");

    // Resync during FIRST (edge 5): first strobe at 5 + 15 = 20.
    push(20, 0, 1, 0); push(50, 0, 2, 0);
    run(55, 5, -1, -1);
    stop("resync_first");

    // Stuff bit on the 3rd strobe (edge 75): byte_done moves to the 9th.
    begin
      int idx_tab[9] = '{1, 2, 2, 3, 4, 5, 6, 7, 0};
      for (int k = 0; k < 9; k++) push(15 + 30 * k, k == 8, idx_tab[k], 1'b0);
    end
    run(258, -1, 75, -1);
    stop("stuff");

    // reset_timer pulse at edge 44: strobe at 45 dropped, restart at 45.
    push(15, 0, 1, 0); push(60, 0, 1, 0); push(90, 0, 2, 0);
    run(95, -1, -1, 44);
    stop("rtp");

    // Asynchronous reset while the 5th strobe is high.
    push(15, 0, 1, 0); push(45, 0, 2, 0); push(75, 0, 3, 0); push(105, 0, 4, 0);
    run(134, -1, -1, -1);
    tick();
    check_eq("pre_rst", 32'({se0, idx0}), 32'({1'b1, 3'd5}));
    #1 rst = 1'b0;
    #1;
    check_eq("async_rst_out", 32'({se0, bd0, idx0}), 32'd0);
    check_eq("async_rst_state", 32'(st0), 32'(IDLE));
    reset_timer = 1'b1;
    #1 rst = 1'b1;
    stop("async");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bit_timer.md
# bit_timer

Parametrised receive bit-timing generator for the USB receiver path. After a start/restart it issues a one-cycle `shift_enable` strobe at a programmable first-sample offset, then once per bit period. It can realign its sampling phase on each detected line transition, and counts sampled bits into bytes with a stuff-bit hold. It replaces the fixed-period timer in front of the receive shift register and feeds the byte-level receive controller.

## Interface
- `CLKS_PER_BIT`, 30: clock cycles per bit period; legal range 4..255.
- `FIRST_OFFSET`, 15: cycles from start to first strobe; legal range 1..`CLKS_PER_BIT`.
- `BITS_PER_BYTE`, 8: strobes per byte; ≥2.
- `RESYNC`, 1: 1 enables phase realignment on `edge_det`; 0 ignores `edge_det`.
- Derived localparams: `CNT_W = $clog2(CLKS_PER_BIT)`, `BIT_W = $clog2(BITS_PER_BYTE)`, `HALF = CLKS_PER_BIT/2` (floor).
- `clk` in 1: system clock, single clock domain.
- `rst` in 1: reset, asynchronous, active-low.
- `reset_timer` in 1: synchronous hold/restart; high forces IDLE.
- `edge_det` in 1: one-cycle pulse on a data-line transition.
- `hold_count` in 1: stuff-bit marker, sampled at the edge a strobe is issued.
- `shift_enable` out 1: registered one-cycle sample strobe.
- `byte_done` out 1: registered one-cycle pulse on the strobe completing a byte.
- `bit_idx` out `BIT_W`: bits counted in the current byte.

## Operation
- States: IDLE, FIRST (waiting for first sample), RUN (periodic sampling).
- Down-counter `cnt` (`CNT_W` bits).
- IDLE:
  - `cnt` = 0, `bit_idx` = 0, no strobes.
  - On an edge with `reset_timer` = 0: load `cnt = FIRST_OFFSET-1`, go to FIRST.
- FIRST/RUN, each edge:
  - `cnt != 0`: decrement.
  - `cnt == 0`: set `shift_enable` = 1, reload `cnt = CLKS_PER_BIT-1`, FIRST goes to RUN.
- Resync (`RESYNC`=1): `edge_det` high on an edge in FIRST or RUN loads `cnt = HALF-1`, so the next strobe falls `HALF` cycles later.
  - If `cnt == 0` on the same edge, the strobe is still issued and the `HALF-1` load wins over the normal reload.
  - In FIRST, resync keeps the state in FIRST.
- Bit counting, on an edge that issues a strobe:
  - `hold_count` = 0: `bit_idx` increments, wrapping `BITS_PER_BYTE-1` → 0. On that wrap `byte_done` is set for the same cycle as `shift_enable`.
  - `hold_count` = 1: `bit_idx` is unchanged and `byte_done` stays 0; `shift_enable` still pulses.
- `reset_timer` high on any edge has priority over everything else.
  - Next cycle: state IDLE, `cnt` = 0, `bit_idx` = 0, `shift_enable` = 0, `byte_done` = 0.
  - A strobe pending on that edge is dropped.
- `rst` low: immediately IDLE, `cnt` = 0, `bit_idx` = 0, `shift_enable` = 0, `byte_done` = 0.

## Timing
- Edge 0 is the first edge at which IDLE samples `reset_timer` = 0.
- First strobe is high in the cycle after edge `FIRST_OFFSET`. Later strobes follow every `CLKS_PER_BIT` cycles.
- A strobe is never high on two consecutive cycles.
- Resync at edge r: next strobe in the cycle after edge r+`HALF`.
- `byte_done` and the `bit_idx` update coincide with their strobe; zero added latency.
- `reset_timer` held high: outputs stay 0. The first strobe after release is again at release edge + `FIRST_OFFSET`.

## Structure
- Package `bit_timer_pkg`:
  - State enum typedef `bt_state_t` (IDLE, FIRST, RUN).
  - Default-parameter constants shared with the receive controller.
- One sub-module, `bit_timer_byte_cnt`: owns `bit_idx`, `byte_done` and `hold_count` gating, driven by an internal strobe-issue signal.
- Phase counter and FSM stay in `bit_timer`.
- Elaboration-time assertions check the parameter ranges.

## Test plan
- Defaults, `reset_timer` 1→0 at edge 0, no edges → strobes after edges 15, 45, 75, …; `bit_idx` 1,2,…,7,0; `byte_done` with the 8th strobe (edge 225).
- `edge_det` at edge 50 (RUN, `cnt` = 25) → next strobe after edge 65, then 95; no strobe at 75.
- `edge_det` on the same edge as `cnt` == 0 (edge 45) → strobe after 45, next after 60.
- `hold_count` = 1 on the 3rd strobe → `bit_idx` stays 2; `byte_done` moves to the 9th strobe.
- `reset_timer` pulsed at edge 44 → no strobe at 45; outputs 0; restart gives first strobe 15 cycles after release.
- `rst` asserted mid-byte (`bit_idx` = 5) → all outputs 0 asynchronously. `RESYNC`=0 build with `edge_det` toggling → strobe timing identical to the no-edge run.
